// File: rtl/dma_pkg.sv
// Shared constants for the DMA bus arbiter: word size, target address,
// default watchdog limit and the arbiter state encoding.
package dma_pkg;

    localparam int WORD_SIZE = 16;
    localparam logic [WORD_SIZE-1:0] DMA_TARGET_ADDR = 16'h01f4;
    localparam int DEFAULT_TIMEOUT = 64;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ISSUE    = 3'd1;
    localparam logic [2:0] ST_WAIT_REQ = 3'd2;
    localparam logic [2:0] ST_GRANT    = 3'd3;
    localparam logic [2:0] ST_RELEASE  = 3'd4;
    localparam logic [2:0] ST_COMPLETE = 3'd5;

    // A transfer is "in flight" from the command pulse until it completes or aborts.
    function automatic logic is_busy_state(input logic [2:0] s);
        return (s == ST_ISSUE) || (s == ST_WAIT_REQ) ||
               (s == ST_GRANT) || (s == ST_RELEASE);
    endfunction

endpackage

// File: rtl/dma_watchdog.sv
// Transfer watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the TIMEOUT-th cycle is reached.
module dma_watchdog
    import dma_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic CLK,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/dma_bus_arbiter.sv
// Arbitrates the memory bus between the CPU and a DMA engine, with cycle
// stealing, CPU priority, a transfer watchdog and per-transfer statistics.
module dma_bus_arbiter
    import dma_pkg::*;
#(
    parameter int TIMEOUT   = DEFAULT_TIMEOUT,
    parameter int STEAL_MIN = 1
) (
    input  logic       CLK,
    input  logic       reset_n,
    input  logic       dma_start,
    input  logic       cpu_bus_req,
    input  logic       BR,
    input  logic       interrupt,
    output logic       cmd,
    output logic       BG,
    output logic       cpu_bus_ok,
    output logic       dma_busy,
    output logic       dma_done,
    output logic       dma_err,
    output logic [3:0] steal_cnt,
    output logic [5:0] grant_cycles
);

    localparam logic [7:0] REL_LAST = 8'((STEAL_MIN > 1) ? STEAL_MIN - 1 : 0);

    logic [2:0] state;
    logic [2:0] next_state;
    logic       err_next;
    logic       steal_inc;
    logic [7:0] rel_cnt;
    logic       wd_clear;
    logic       wd_enable;
    logic       wd_expire;
    logic       rel_done;

    assign wd_clear  = (state == ST_IDLE) && dma_start;
    assign wd_enable = is_busy_state(state);
    assign rel_done  = (rel_cnt >= REL_LAST);

    dma_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .CLK    (CLK),
        .reset_n(reset_n),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    // Interrupt beats the watchdog; the watchdog beats a bus release.
    always_comb begin
        next_state = state;
        err_next   = 1'b0;
        steal_inc  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dma_start) next_state = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (wd_expire) begin
                    next_state = ST_IDLE;
                    err_next   = 1'b1;
                end else begin
                    next_state = ST_WAIT_REQ;
                end
            end
            ST_WAIT_REQ: begin
                if (wd_expire) begin
                    next_state = ST_IDLE;
                    err_next   = 1'b1;
                end else if (BR && !cpu_bus_req) begin
                    next_state = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (interrupt) begin
                    next_state = ST_COMPLETE;
                end else if (wd_expire) begin
                    next_state = ST_IDLE;
                    err_next   = 1'b1;
                end else if (!BR) begin
                    next_state = ST_RELEASE;
                    steal_inc  = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (interrupt) begin
                    next_state = ST_COMPLETE;
                end else if (wd_expire) begin
                    next_state = ST_IDLE;
                    err_next   = 1'b1;
                end else if (rel_done && BR && !cpu_bus_req) begin
                    next_state = ST_GRANT;
                end
            end
            ST_COMPLETE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cmd        <= 1'b0;
            BG         <= 1'b0;
            cpu_bus_ok <= 1'b1;
            dma_busy   <= 1'b0;
            dma_done   <= 1'b0;
            dma_err    <= 1'b0;
        end else begin
            state      <= next_state;
            cmd        <= (next_state == ST_ISSUE);
            BG         <= (next_state == ST_GRANT);
            cpu_bus_ok <= (next_state != ST_GRANT);
            dma_busy   <= is_busy_state(next_state);
            dma_done   <= (next_state == ST_COMPLETE);
            dma_err    <= err_next;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            rel_cnt <= '0;
        end else if (state != ST_RELEASE) begin
            rel_cnt <= '0;
        end else if (rel_cnt != 8'hff) begin
            rel_cnt <= rel_cnt + 1'b1;
        end
    end

    // Statistics restart with each new transfer and hold after it ends.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            steal_cnt    <= '0;
            grant_cycles <= '0;
        end else if (wd_clear) begin
            steal_cnt    <= '0;
            grant_cycles <= '0;
        end else begin
            if (steal_inc && (steal_cnt != 4'd15)) begin
                steal_cnt <= steal_cnt + 1'b1;
            end
            if ((state == ST_GRANT) && (grant_cycles != 6'd63)) begin
                grant_cycles <= grant_cycles + 1'b1;
            end
        end
    end

endmodule
